// File: rtl/sram_line_fetcher.sv
// rtl/sram_line_fetcher.sv - double-buffered SRAM line fetcher feeding 4-bit palette indices
module sram_line_fetcher #(
    parameter logic [19:0] BASE_ADDR      = 20'h00000,
    parameter int          WORDS_PER_LINE = 160,
    parameter int          LINES          = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    input  logic [9:0]  DrawX,
    input  logic        done_r,
    input  logic [15:0] sram_data,
    output logic        Read,
    output logic [19:0] addr_out,
    output logic [3:0]  pixel_idx,
    output logic        fetch_busy,
    output logic        line_done,
    output logic        overrun
);
    localparam int WIW = $clog2(WORDS_PER_LINE + 1);
    localparam int MAW = $clog2(2 * WORDS_PER_LINE);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ABORT} state_t;

    state_t         state_q, state_d;
    logic [WIW-1:0] word_idx_q, word_idx_d;
    logic           disp_bank_q, disp_bank_d;
    logic [1:0]     blank_q, blank_d;
    logic [19:0]    line_base_q, line_base_d;
    logic           in_range_q, in_range_d;
    logic [19:0]    addr_q, addr_d;
    logic           read_q, read_d;
    logic           busy_q, busy_d;
    logic           line_done_q, line_done_d;
    logic           overrun_q, overrun_d;
    logic [3:0]     pixel_q, pixel_d;

    logic [15:0]    bank_mem [0:2*WORDS_PER_LINE-1];

    logic           start_in_range;
    logic           restart_ev;
    logic           restart_in_range;
    logic           blank_finish;
    logic           last_word;
    logic           fill_bank;
    logic           wr_en;
    logic [MAW-1:0] wr_addr;
    logic [MAW-1:0] rd_addr;
    logic [7:0]     rd_word;
    logic           pix_in_range;
    logic [15:0]    rd_data;
    logic [3:0]     nib;

    assign start_in_range   = {23'd0, line_num} < 32'(LINES);
    // The outstanding transaction has just completed while a new line is pending.
    assign restart_ev       = ((state_q == S_WAIT) && line_start && done_r) ||
                              ((state_q == S_ABORT) && done_r);
    assign restart_in_range = line_start ? start_in_range : in_range_q;
    assign blank_finish     = (((state_q == S_IDLE) && line_start) || restart_ev) && !restart_in_range;
    assign last_word        = (word_idx_q == LAST_WORD);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (line_start && start_in_range) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = line_start ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (restart_ev)      state_d = restart_in_range ? S_REQ : S_IDLE;
                else if (line_start) state_d = S_ABORT;
                else if (done_r)     state_d = last_word ? S_IDLE : S_REQ;
            end
            S_ABORT: begin
                if (restart_ev) state_d = restart_in_range ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp_bank_d = disp_bank_q ^ line_start;
        fill_bank   = ~disp_bank_d;
        word_idx_d  = word_idx_q;
        line_base_d = line_base_q;
        in_range_d  = in_range_q;
        blank_d     = blank_q;
        wr_en       = 1'b0;
        if (line_start) begin
            word_idx_d         = '0;
            line_base_d        = BASE_ADDR + 20'(line_num) * 20'(WORDS_PER_LINE);
            in_range_d         = start_in_range;
            blank_d[fill_bank] = 1'b0;
        end else if ((state_q == S_WAIT) && done_r) begin
            wr_en      = 1'b1;
            word_idx_d = word_idx_q + 1'b1;
        end
        if (blank_finish) blank_d[fill_bank] = 1'b1;
        addr_d      = (state_d == S_REQ) ? line_base_d + 20'(word_idx_d) : addr_q;
        read_d      = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
        line_done_d = blank_finish ||
                      ((state_q == S_WAIT) && done_r && !line_start && last_word);
        overrun_d   = overrun_q || (line_start && (state_q != S_IDLE));
    end

    // Display-side read: word/nibble select from the bank not being filled.
    always_comb begin
        rd_word      = DrawX[9:2];
        pix_in_range = {22'd0, DrawX} < 32'(4 * WORDS_PER_LINE);
        rd_addr      = MAW'(disp_bank_q ? WORDS_PER_LINE : 0) + (pix_in_range ? MAW'(rd_word) : '0);
        wr_addr      = MAW'(fill_bank ? WORDS_PER_LINE : 0) + MAW'(word_idx_q);
        rd_data      = bank_mem[rd_addr];
        case (DrawX[1:0])
            2'd0:    nib = rd_data[15:12];
            2'd1:    nib = rd_data[11:8];
            2'd2:    nib = rd_data[7:4];
            default: nib = rd_data[3:0];
        endcase
        pixel_d = (!pix_in_range || blank_q[disp_bank_q]) ? 4'd0 : nib;
    end

    always_ff @(posedge Clk) begin
        if (Reset && wr_en) bank_mem[wr_addr] <= sram_data;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            word_idx_q  <= '0;
            disp_bank_q <= 1'b0;
            blank_q     <= 2'b11;
            line_base_q <= '0;
            in_range_q  <= 1'b0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            pixel_q     <= '0;
        end else begin
            word_idx_q  <= word_idx_d;
            disp_bank_q <= disp_bank_d;
            blank_q     <= blank_d;
            line_base_q <= line_base_d;
            in_range_q  <= in_range_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
            pixel_q     <= pixel_d;
        end
    end

    assign Read       = read_q;
    assign addr_out   = addr_q;
    assign pixel_idx  = pixel_q;
    assign fetch_busy = busy_q;
    assign line_done  = line_done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_sram_line_fetcher.sv
// tb/tb_sram_line_fetcher.sv - self-checking bench for sram_line_fetcher
module tb_sram_line_fetcher;
    logic        clk = 1'b0;
    logic        Reset;
    logic        line_start;
    logic [8:0]  line_num;
    logic [9:0]  DrawX;
    logic        done_r = 1'b0;
    logic [15:0] sram_data = 16'd0;
    logic        Read, fetch_busy, line_done, overrun;
    logic [19:0] addr_out;
    logic [3:0]  pixel_idx;
    logic        read2, busy2, ld2, ovr2;
    logic [19:0] addr2;
    logic [3:0]  pix2;

    logic [15:0] key = 16'hAA8D;
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          rd_count = 0, ld_count = 0, overlap_errs = 0, lock_errs = 0, cnt = 0, ld_cyc = 0;
    int          rd_cyc   [8192];
    logic [19:0] rd_addr  [8192];
    logic [19:0] rd_addr2 [8192];
    logic [19:0] pend_addr = '0;

    sram_line_fetcher u_dut (
        .Clk(clk), .Reset(Reset), .line_start(line_start), .line_num(line_num), .DrawX(DrawX),
        .done_r(done_r), .sram_data(sram_data), .Read(Read), .addr_out(addr_out),
        .pixel_idx(pixel_idx), .fetch_busy(fetch_busy), .line_done(line_done), .overrun(overrun)
    );

    sram_line_fetcher #(.BASE_ADDR(20'hFFFF0)) u_wrap (
        .Clk(clk), .Reset(Reset), .line_start(line_start), .line_num(line_num), .DrawX(DrawX),
        .done_r(done_r), .sram_data(sram_data), .Read(read2), .addr_out(addr2),
        .pixel_idx(pix2), .fetch_busy(busy2), .line_done(ld2), .overrun(ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 3-cycle SRAM controller: data returns two cycles after the Read cycle.
    always @(negedge clk) begin
        if (!Reset) begin
            cnt    = 0;
            done_r = 1'b0;
        end else begin
            done_r = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done_r    = 1'b1;
                    sram_data = pend_addr[15:0] ^ key;
                end
            end
            if (Read) begin
                if (cnt != 0 || done_r) overlap_errs++;
                if (rd_count < 8192) begin
                    rd_cyc[rd_count]   = cyc;
                    rd_addr[rd_count]  = addr_out;
                    rd_addr2[rd_count] = addr2;
                end
                rd_count++;
                cnt       = 2;
                pend_addr = addr_out;
            end
            if (line_done) begin
                ld_count++;
                ld_cyc = cyc;
            end
        end
        if ({read2, busy2, ld2, ovr2, pix2} !== {Read, fetch_busy, line_done, overrun, pixel_idx})
            lock_errs++;
    end

    typedef struct {
        int         dx;
        logic [3:0] pix;
    } vec_t;
    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_pix(input int line, input int dx);
        int          a;
        logic [15:0] d;
        if (dx >= 640 || line >= 480) return 4'd0;
        a = (line * 160 + dx / 4) % (1 << 20);
        d = 16'(a) ^ key;
        return 4'((d >> (4 * (3 - dx % 4))) & 16'hF);
    endfunction

    function automatic int seq_errs(input int b, input int n, input int line);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (rd_addr[b + i] !== 20'(line * 160 + i)) e++;
        return e;
    endfunction

    int s_cyc = 0;

    task automatic start_line(input int ln);
        line_num   = 9'(ln);
        line_start = 1'b1;
        s_cyc      = cyc;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_ld(input int lb, input string name);
        int t = 0;
        while (ld_count == lb && t < 1000) begin
            tick();
            t++;
        end
        chk({name, "_done_seen"}, 32'(ld_count > lb), 32'd1);
    endtask

    task automatic chk_pix(input string name, input int dx, input int line);
        DrawX = 10'(dx);
        tick();
        chk(name, 32'(pixel_idx), 32'(model_pix(line, dx)));
    endtask

    initial begin
        int rb, lb, rk, s2, t, nl, disp_line, fill_line, perr;

        tbl[0] = '{0, 4'hA};   tbl[1] = '{1, 4'hB};   tbl[2] = '{2, 4'hC};
        tbl[3] = '{3, 4'hD};   tbl[4] = '{7, 4'hC};   tbl[5] = '{636, 4'hA};
        tbl[6] = '{639, 4'h2}; tbl[7] = '{640, 4'h0}; tbl[8] = '{1023, 4'h0};

        Reset = 1'b0; line_start = 1'b0; line_num = '0; DrawX = '0;
        repeat (3) begin
            DrawX = 10'($urandom_range(0, 1023));
            tick();
        end
        chk("rst_pixel", 32'(pixel_idx), 0);
        chk("rst_read", 32'(Read), 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_addr", 32'(addr_out), 0);
        Reset = 1'b1;
        tick();

        // Line 2 with the 3-cycle controller.
        rb = rd_count; lb = ld_count;
        start_line(2);
        wait_ld(lb, "l2");
        chk("l2_reads", 32'(rd_count - rb), 160);
        chk("l2_first_cyc", 32'(rd_cyc[rb] - s_cyc), 1);
        chk("l2_second_cyc", 32'(rd_cyc[rb + 1] - s_cyc), 4);
        chk("l2_first_addr", 32'(rd_addr[rb]), 320);
        chk("l2_addr_seq", 32'(seq_errs(rb, 160, 2)), 0);
        chk("l2_done_cyc", 32'(ld_cyc - s_cyc), 481);
        tick();
        chk("l2_idle_busy", 32'(fetch_busy), 0);
        chk("l2_done_once", 32'(ld_count - lb), 1);

        // Swap to line 2; fetch line 0 in the background (also exercises address wrap).
        rb = rd_count; lb = ld_count;
        start_line(0);
        for (int i = 0; i < 9; i++) begin
            DrawX = 10'(tbl[i].dx);
            tick();
            chk($sformatf("tbl_pix_dx%0d", tbl[i].dx), 32'(pixel_idx), 32'(tbl[i].pix));
        end
        DrawX = 10'd0;
        tick();
        DrawX = 10'd3;
        #1;
        chk("pix_latency_hold", 32'(pixel_idx), 32'hA);
        tick();
        chk("pix_latency_new", 32'(pixel_idx), 32'hD);
        wait_ld(lb, "l0");
        chk("l0_addr_seq", 32'(seq_errs(rb, 160, 0)), 0);
        chk("wrap_word15", 32'(rd_addr2[rb + 15]), 32'hFFFFF);
        chk("wrap_word16", 32'(rd_addr2[rb + 16]), 32'h00000);

        // Out-of-range line: no Read, line_done next cycle, then blank display.
        rb = rd_count; lb = ld_count;
        start_line(480);
        chk("oor_done_pulse", 32'(line_done), 1);
        chk("oor_busy", 32'(fetch_busy), 0);
        tick();
        chk("oor_done_drop", 32'(line_done), 0);
        repeat (10) tick();
        chk("oor_no_read", 32'(rd_count - rb), 0);
        lb = ld_count;
        start_line(10);
        perr = 0;
        for (int dx = 0; dx < 1024; dx += 37) begin
            DrawX = 10'(dx);
            tick();
            if (pixel_idx !== 4'd0) perr++;
        end
        chk("blank_display", 32'(perr), 0);
        wait_ld(lb, "l10");

        // Overrun during word 50 of line 4.
        chk("pre_overrun", 32'(overrun), 0);
        rb = rd_count; lb = ld_count;
        start_line(4);
        t = 0;
        while (rd_count - rb < 51 && t < 1000) begin
            tick();
            t++;
        end
        chk("l4_reach_word50", 32'(rd_count - rb), 51);
        rk = rd_count;
        start_line(5);
        s2 = s_cyc;
        chk("overrun_set", 32'(overrun), 1);
        wait_ld(lb, "l5");
        chk("l5_restart_addr", 32'(rd_addr[rk]), 800);
        chk("l5_restart_cyc", 32'(rd_cyc[rk] - s2), 2);
        chk("l5_addr_seq", 32'(seq_errs(rk, 160, 5)), 0);
        chk("l4_no_done", 32'(ld_count - lb), 1);

        // Swap to line 5, then line_start coinciding with done_r.
        rb = rd_count; lb = ld_count;
        start_line(7);
        perr = 0;
        for (int dx = 0; dx < 640; dx += 3) begin
            DrawX = 10'(dx);
            tick();
            if (pixel_idx !== model_pix(5, dx)) perr++;
        end
        chk("l5_display", 32'(perr), 0);
        t = 0;
        while (!(rd_count - rb >= 20 && cnt == 1) && t < 1000) begin
            tick();
            t++;
        end
        chk("coincide_ready", 32'(cnt), 1);
        rk = rd_count;
        start_line(9);
        s2 = s_cyc;
        wait_ld(lb, "l9");
        chk("coincide_addr", 32'(rd_addr[rk]), 1440);
        chk("coincide_cyc", 32'(rd_cyc[rk] - s2), 1);
        chk("coincide_reads", 32'(rd_count - rk), 160);
        chk("l7_no_done", 32'(ld_count - lb), 1);

        // Random lines checked against the pixel model.
        fill_line = 9;
        for (int it = 0; it < 6; it++) begin
            nl = (it == 2) ? 500 : int'($urandom_range(0, 511));
            rb = rd_count; lb = ld_count;
            start_line(nl);
            disp_line = fill_line;
            fill_line = nl;
            for (int k = 0; k < 24; k++)
                chk_pix($sformatf("rnd%0d_pix", it), int'($urandom_range(0, 1023)), disp_line);
            wait_ld(lb, $sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_reads", it), 32'(rd_count - rb), (nl < 480) ? 160 : 0);
            if (nl < 480) chk($sformatf("rnd%0d_seq", it), 32'(seq_errs(rb, 160, nl)), 0);
        end

        // Reset in the middle of a fetch.
        start_line(3);
        repeat (20) tick();
        Reset = 1'b0;
        tick();
        chk("midrst_read", 32'(Read), 0);
        chk("midrst_busy", 32'(fetch_busy), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_addr", 32'(addr_out), 0);
        Reset = 1'b1;
        DrawX = 10'd8;
        tick();
        chk("midrst_pixel", 32'(pixel_idx), 0);
        rb = rd_count; lb = ld_count;
        repeat (30) tick();
        chk("midrst_no_read", 32'(rd_count - rb), 0);
        chk("midrst_no_done", 32'(ld_count - lb), 0);

        chk("no_read_overlap", 32'(overlap_errs), 0);
        chk("wrap_lockstep", 32'(lock_errs), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
